// File: rtl/bitstream_packer_pkg.sv
// Shared constants, FSM encoding and output word payload for the bitstream packer.
package bitstream_packer_pkg;

  localparam int unsigned ACC_W       = 64;
  localparam int unsigned MAX_VLC_LEN = 32;
  localparam int unsigned LEN_W       = 6;
  localparam int unsigned VLC_W       = 32;
  localparam int unsigned BYTE_W      = 8;
  localparam int unsigned WORD_W      = 16;

  localparam logic [BYTE_W-1:0] EP_BYTE = 8'h03;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    LAST  = 2'd2
  } state_t;

  typedef struct packed {
    logic [WORD_W-1:0] data;
    logic              half;
    logic              last;
    logic              removed;
  } word_t;

endpackage

// File: rtl/bitstream_packer_if.sv
// Code input and word output handshakes of the packer; slave is the packer's view.
interface bitstream_packer_if;
  import bitstream_packer_pkg::*;

  logic              vlc_valid;
  logic              vlc_ready;
  logic [VLC_W-1:0]  vlc_data;
  logic [LEN_W-1:0]  vlc_len;
  logic              vlc_flush;
  logic              out_valid;
  logic              out_ready;
  logic [WORD_W-1:0] out_data;
  logic              out_half;
  logic              out_last;
  logic              removed_03;

  modport slave (
    input  vlc_valid, vlc_data, vlc_len, vlc_flush, out_ready,
    output vlc_ready, out_valid, out_data, out_half, out_last, removed_03
  );

  modport master (
    output vlc_valid, vlc_data, vlc_len, vlc_flush, out_ready,
    input  vlc_ready, out_valid, out_data, out_half, out_last, removed_03
  );

endinterface

// File: rtl/bitstream_packer_ep_insert.sv
// Byte stage that inserts 0x03 after two zero bytes when the next byte is 0x00..0x03.
module bitstream_packer_ep_insert
  import bitstream_packer_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic              inValid,
  output logic              inReady_c,
  input  logic [BYTE_W-1:0] inByte,
  output logic              outValid,
  input  logic              outReady,
  output logic [BYTE_W-1:0] outByte,
  output logic              outFlag,
  output logic              pendValid,
  input  logic              clrZeroRun
);

  logic [BYTE_W-1:0] pendByte;
  logic [1:0]        zeroRun;
  logic              slotFree;
  logic              insertNeeded;
  logic [1:0]        zeroRunBase;
  logic [1:0]        zeroRunNext;

  // Handshake and zero-run bookkeeping for the byte offered this cycle
  always_comb begin
    slotFree     = !outValid || outReady;
    inReady_c    = !pendValid && slotFree;
    insertNeeded = (zeroRun == 2'd2) && (inByte <= EP_BYTE);
    zeroRunBase  = insertNeeded ? 2'd0 : zeroRun;
    zeroRunNext  = 2'd0;
    if (inByte == 8'h00) begin
      zeroRunNext = (zeroRunBase == 2'd2) ? 2'd2 : zeroRunBase + 2'd1;
    end
  end

  // Output byte register; an inserted 0x03 parks the original byte for one extra slot
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      outValid  <= 1'b0;
      outByte   <= '0;
      outFlag   <= 1'b0;
      pendValid <= 1'b0;
      pendByte  <= '0;
      zeroRun   <= 2'd0;
    end else begin
      if (pendValid && slotFree) begin
        outValid  <= 1'b1;
        outByte   <= pendByte;
        outFlag   <= 1'b0;
        pendValid <= 1'b0;
      end else if (inValid && inReady_c) begin
        outValid <= 1'b1;
        zeroRun  <= zeroRunNext;
        if (insertNeeded) begin
          outByte   <= EP_BYTE;
          outFlag   <= 1'b1;
          pendByte  <= inByte;
          pendValid <= 1'b1;
        end else begin
          outByte <= inByte;
          outFlag <= 1'b0;
        end
      end else if (outReady) begin
        outValid <= 1'b0;
      end
      if (clrZeroRun) begin
        zeroRun <= 2'd0;
      end
    end
  end

endmodule

// File: rtl/bitstream_packer.sv
// Packs variable-length codes MSB-first, inserts emulation prevention and emits 16-bit words.
module bitstream_packer
  import bitstream_packer_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  bitstream_packer_if.slave io
);

  localparam int unsigned CNT_W = $clog2(ACC_W + 1);
  localparam logic [ACC_W-1:0] STOP_BIT = {1'b1, {(ACC_W-1){1'b0}}};

  state_t            state;
  logic [ACC_W-1:0]  acc, accNext, baseAcc, codeMask, codeAligned;
  logic [CNT_W-1:0]  cnt, cntNext, baseCnt;
  logic              padPending, padApply, vlcReady, accept, drain;
  logic              epInReady, epOutValid, epOutFlag, epPendValid;
  logic [BYTE_W-1:0] epOutByte;
  logic              hiValid, hiFlag;
  logic [BYTE_W-1:0] hiByte;
  word_t             word, skidWord, outWord;
  logic              wordValid, skidValid, outValid;
  logic              byteFire, lastByte, outFire, clrZeroRun;

  // Accumulator next value: optional byte drain, then code or stop-bit append below the valid bits
  always_comb begin
    drain       = (cnt >= CNT_W'(BYTE_W)) && epInReady;
    baseAcc     = drain ? (acc << BYTE_W) : acc;
    baseCnt     = drain ? (cnt - CNT_W'(BYTE_W)) : cnt;
    accept      = io.vlc_valid && vlcReady;
    codeMask    = (ACC_W'(1) << io.vlc_len) - ACC_W'(1);
    codeAligned = ((ACC_W'(io.vlc_data) & codeMask) << (CNT_W'(ACC_W) - CNT_W'(io.vlc_len))) >> baseCnt;
    padApply    = padPending && (baseCnt < CNT_W'(ACC_W));
    accNext     = baseAcc;
    cntNext     = baseCnt;
    if (accept) begin
      accNext = baseAcc | codeAligned;
      cntNext = baseCnt + CNT_W'(io.vlc_len);
    end else if (padApply) begin
      // Stop bit, then zero padding up to the next byte boundary
      accNext = baseAcc | (STOP_BIT >> baseCnt);
      cntNext = (baseCnt + CNT_W'(BYTE_W)) & ~CNT_W'(BYTE_W - 1);
    end
  end

  // Accumulator register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc <= '0;
      cnt <= '0;
    end else begin
      acc <= accNext;
      cnt <= cntNext;
    end
  end

  bitstream_packer_ep_insert epInsert (
    .clk        (clk),
    .reset_n    (reset_n),
    .inValid    (cnt >= CNT_W'(BYTE_W)),
    .inReady_c  (epInReady),
    .inByte     (acc[ACC_W-1 -: BYTE_W]),
    .outValid   (epOutValid),
    .outReady   (!skidValid),
    .outByte    (epOutByte),
    .outFlag    (epOutFlag),
    .pendValid  (epPendValid),
    .clrZeroRun (clrZeroRun)
  );

  // Word formation; the final byte of a NAL closes the word, as a half word if unpaired
  always_comb begin
    byteFire     = epOutValid && !skidValid;
    lastByte     = (state == DRAIN) && !padPending && (cnt == '0) && !epPendValid;
    wordValid    = byteFire && (hiValid || lastByte);
    word         = '0;
    word.data    = hiValid ? {hiByte, epOutByte} : {epOutByte, 8'h00};
    word.half    = !hiValid;
    word.last    = lastByte;
    word.removed = (hiValid && hiFlag) || epOutFlag;
    outFire      = outValid && io.out_ready;
    clrZeroRun   = (state == LAST) && outFire && outWord.last;
  end

  // Odd-byte holder, skid register and output register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hiValid   <= 1'b0;
      hiByte    <= '0;
      hiFlag    <= 1'b0;
      skidValid <= 1'b0;
      skidWord  <= '0;
      outValid  <= 1'b0;
      outWord   <= '0;
    end else begin
      if (byteFire) begin
        hiValid <= !wordValid;
        hiByte  <= epOutByte;
        hiFlag  <= epOutFlag;
      end
      if (!outValid || io.out_ready) begin
        if (skidValid) begin
          outWord   <= skidWord;
          outValid  <= 1'b1;
          skidValid <= 1'b0;
        end else if (wordValid) begin
          outWord  <= word;
          outValid <= 1'b1;
        end else begin
          outValid <= 1'b0;
        end
      end else if (wordValid) begin
        skidWord  <= word;
        skidValid <= 1'b1;
      end
    end
  end

  // NAL framing FSM; vlc_ready is registered from the next accumulator fill level
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= RUN;
      padPending <= 1'b0;
      vlcReady   <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          if (accept && io.vlc_flush) begin
            state      <= DRAIN;
            padPending <= 1'b1;
            vlcReady   <= 1'b0;
          end else begin
            vlcReady <= (cntNext <= CNT_W'(MAX_VLC_LEN));
          end
        end
        DRAIN: begin
          vlcReady <= 1'b0;
          if (padApply) begin
            padPending <= 1'b0;
          end
          if (byteFire && lastByte) begin
            state <= LAST;
          end
        end
        LAST: begin
          if (clrZeroRun) begin
            state    <= RUN;
            vlcReady <= 1'b1;
          end
        end
        default: begin
          state    <= RUN;
          vlcReady <= 1'b0;
        end
      endcase
    end
  end

  assign io.vlc_ready  = vlcReady;
  assign io.out_valid  = outValid;
  assign io.out_data   = outWord.data;
  assign io.out_half   = outWord.half;
  assign io.out_last   = outWord.last;
  assign io.removed_03 = outWord.removed;

  // Codes longer than the maximum length are not supported
  assert property (@(posedge clk) disable iff (!reset_n)
    io.vlc_valid |-> (io.vlc_len <= LEN_W'(MAX_VLC_LEN)));

  // Accepting a code must never overflow the accumulator
  assert property (@(posedge clk) disable iff (!reset_n)
    vlcReady |-> (cnt <= CNT_W'(MAX_VLC_LEN)));

endmodule
